control_pipe: RTL and testbench

Parametrised, registered successor to the decode-stage control unit. Decodes one opcode per cycle into datapath and TPU control and holds the result in a single output register stage with a valid/stall handshake. Generalises TPU matrix-buffer loads to TPU_BUFS buffers. Tracks multi-cycle matmul occupancy so later TPU-class ops back-pressure the fetch side until the TPU is free.

---
 rtl/control_pipe_if.sv | 37 +++
 rtl/control_pipe.sv | 160 ++++++++++++++++
 tb/tb_control_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/control_pipe_if.sv
// Fetch/decode handshake bundle for control_pipe: instruction and flow
// control toward the decoder, registered control word and status back.
interface control_pipe_if #(
    parameter int OP_W     = 7,
    parameter int TPU_BUFS = 3
);
    logic                valid_i;
    logic [OP_W-1:0]     op_i;
    logic                stall_i;
    logic                flush_i;
    logic                ready_o;
    logic                valid_o;
    logic                imm_sel_o;
    logic [3:0]          alu_op_o;
    logic [1:0]          branch_type_o;
    logic [1:0]          wb_sel_o;
    logic                reg_write_enable_o;
    logic                mem_write_enable_o;
    logic                tpu_start_o;
    logic [TPU_BUFS-1:0] tpu_write_enable_o;
    logic                tpu_busy_o;
    logic                illegal_o;

    modport master (
        output valid_i, op_i, stall_i, flush_i,
        input  ready_o, valid_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o,
               reg_write_enable_o, mem_write_enable_o, tpu_start_o,
               tpu_write_enable_o, tpu_busy_o, illegal_o
    );

    modport slave (
        input  valid_i, op_i, stall_i, flush_i,
        output ready_o, valid_o, imm_sel_o, alu_op_o, branch_type_o, wb_sel_o,
               reg_write_enable_o, mem_write_enable_o, tpu_start_o,
               tpu_write_enable_o, tpu_busy_o, illegal_o
    );
endinterface

// File: rtl/control_pipe.sv
// Registered decode-stage control unit. One opcode per cycle is decoded into
// datapath and TPU control and held in a single output register with a
// valid/stall/flush handshake. A busy counter tracks matmul occupancy so that
// later TPU-class ops are held off at the fetch side until the TPU is free.
module control_pipe #(
    parameter int OP_W     = 7,
    parameter int TPU_BUFS = 3,
    parameter int TPU_LAT  = 16,
    parameter int CNT_W    = $clog2(TPU_LAT + 1)
) (
    input logic           clk,
    input logic           rst_n,
    control_pipe_if.slave bus
);
    localparam logic [6:0]       MATMUL_OP     = 7'h50;
    localparam logic [6:0]       LOAD_FIRST_OP = 7'h51;
    localparam int               RACC_INT      = 32'h51 + TPU_BUFS;
    localparam logic [6:0]       RACC_OP       = 7'(RACC_INT);
    localparam logic [CNT_W-1:0] LAT_CNT       = CNT_W'(TPU_LAT);

    logic [6:0]          op7_s;
    logic                hi_bad_s;
    logic [3:0]          alu_op_s;
    logic [1:0]          branch_type_s;
    logic [1:0]          wb_sel_s;
    logic                imm_sel_s;
    logic                reg_we_s;
    logic                mem_we_s;
    logic                tpu_start_s;
    logic [TPU_BUFS-1:0] tpu_we_s;
    logic                illegal_s;
    logic                tpu_class_s;
    logic                busy_s;
    logic                hazard_s;
    logic                ready_s;
    logic                accept_s;
    logic                consume_s;

    logic                valid_r;
    logic [3:0]          alu_op_r;
    logic [1:0]          branch_type_r;
    logic [1:0]          wb_sel_r;
    logic                imm_sel_r;
    logic                reg_we_r;
    logic                mem_we_r;
    logic                tpu_start_r;
    logic [TPU_BUFS-1:0] tpu_we_r;
    logic                illegal_r;
    logic [CNT_W-1:0]    cnt_r;

    assign op7_s = bus.op_i[6:0];

    // Any set bit above the 7-bit opcode space makes the opcode illegal.
    generate
        if (OP_W > 7) begin : g_hi_bits
            assign hi_bad_s = |bus.op_i[OP_W-1:7];
        end else begin : g_no_hi_bits
            assign hi_bad_s = 1'b0;
        end
    endgenerate

    // Decode fields from op[6:0] and the enables from the defined opcode map.
    always_comb begin
        wb_sel_s    = {(op7_s[6:4] == 3'b101), (op7_s[6:4] == 3'b010)};
        alu_op_s    = wb_sel_s[0] ? 4'h1 : op7_s[3:0];
        imm_sel_s   = op7_s[4] ^ op7_s[5];
        reg_we_s    = 1'b0;
        mem_we_s    = 1'b0;
        tpu_start_s = 1'b0;
        tpu_we_s    = '0;
        illegal_s   = 1'b0;
        if (op7_s[6:4] == 3'b011) begin
            branch_type_s = 2'b01;
        end else if (&op7_s[6:1]) begin
            branch_type_s = {1'b1, op7_s[0]};
        end else begin
            branch_type_s = 2'b00;
        end
        if (hi_bad_s) begin
            illegal_s = 1'b1;
        end else if ((op7_s >= 7'h01 && op7_s <= 7'h0A) || op7_s == 7'h11 ||
                     (op7_s >= 7'h13 && op7_s <= 7'h19) || op7_s == 7'h1B ||
                     op7_s == 7'h20 || op7_s == RACC_OP) begin
            reg_we_s = 1'b1;
        end else if (op7_s == 7'h21) begin
            mem_we_s = 1'b1;
        end else if (op7_s == MATMUL_OP) begin
            tpu_start_s = 1'b1;
        end else if (op7_s >= LOAD_FIRST_OP && op7_s < RACC_OP) begin
            for (int b = 0; b < TPU_BUFS; b++) begin
                tpu_we_s[b] = (op7_s == LOAD_FIRST_OP + 7'(b));
            end
        end else if (op7_s == 7'h00 || (op7_s >= 7'h3C && op7_s <= 7'h3F) ||
                     op7_s >= 7'h7E) begin
            illegal_s = 1'b0;
        end else begin
            illegal_s = 1'b1;
        end
    end

    // TPU-class ops (matmul, buffer loads, racc) wait while the TPU is busy;
    // a matmul still sitting in the output register already counts as busy.
    assign tpu_class_s = ~hi_bad_s & (op7_s >= MATMUL_OP) & (op7_s <= RACC_OP);
    assign busy_s      = (cnt_r != '0) | (valid_r & tpu_start_r);
    assign hazard_s    = bus.valid_i & tpu_class_s & busy_s;
    assign ready_s     = ~bus.stall_i & ~bus.flush_i & ~hazard_s;
    assign accept_s    = bus.valid_i & ready_s;
    assign consume_s   = valid_r & tpu_start_r & ~bus.stall_i & ~bus.flush_i;

    // Output register: flush clears, accept loads, stall holds, else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush_i || (!accept_s && !bus.stall_i)) begin
            valid_r       <= 1'b0;
            alu_op_r      <= 4'h0;
            branch_type_r <= 2'b00;
            wb_sel_r      <= 2'b00;
            imm_sel_r     <= 1'b0;
            reg_we_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            tpu_start_r   <= 1'b0;
            tpu_we_r      <= '0;
            illegal_r     <= 1'b0;
        end else if (accept_s) begin
            valid_r       <= 1'b1;
            alu_op_r      <= alu_op_s;
            branch_type_r <= branch_type_s;
            wb_sel_r      <= wb_sel_s;
            imm_sel_r     <= imm_sel_s;
            reg_we_r      <= reg_we_s;
            mem_we_r      <= mem_we_s;
            tpu_start_r   <= tpu_start_s;
            tpu_we_r      <= tpu_we_s;
            illegal_r     <= illegal_s;
        end
    end

    // Occupancy counter: reload when a matmul is consumed, else count down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (consume_s) begin
            cnt_r <= LAT_CNT;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    assign bus.ready_o            = ready_s;
    assign bus.valid_o            = valid_r;
    assign bus.imm_sel_o          = imm_sel_r;
    assign bus.alu_op_o           = alu_op_r;
    assign bus.branch_type_o      = branch_type_r;
    assign bus.wb_sel_o           = wb_sel_r;
    assign bus.reg_write_enable_o = reg_we_r;
    assign bus.mem_write_enable_o = mem_we_r;
    assign bus.tpu_start_o        = tpu_start_r;
    assign bus.tpu_write_enable_o = tpu_we_r;
    assign bus.tpu_busy_o         = busy_s;
    assign bus.illegal_o          = illegal_r;
endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: two instances (default parameters, and OP_W=8 /
// TPU_BUFS=4 / TPU_LAT=5) share one stimulus stream and are compared every
// cycle against an opcode-table reference model.
module tb_control_pipe;
    typedef struct packed {
        logic [3:0]  alu;
        logic [1:0]  br;
        logic [1:0]  wb;
        logic        imm;
        logic        regw;
        logic        memw;
        logic        start;
        logic [15:0] we;
        logic        ill;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vin, stall, flush;
    logic [7:0] op;

    int   n_checks = 0;
    int   n_err    = 0;
    int   lat [2]  = '{16, 5};
    int   bufs [2] = '{3, 4};
    bit   mv [2];
    bit   mknown [2];
    dec_t mcur [2];
    int   mcnt [2];
    bit   last_ready0;

    always #5 clk = ~clk;

    control_pipe_if #(.OP_W(7), .TPU_BUFS(3)) bus0 ();
    control_pipe_if #(.OP_W(8), .TPU_BUFS(4)) bus1 ();

    assign bus0.valid_i = vin;
    assign bus0.op_i    = op[6:0];
    assign bus0.stall_i = stall;
    assign bus0.flush_i = flush;
    assign bus1.valid_i = vin;
    assign bus1.op_i    = op;
    assign bus1.stall_i = stall;
    assign bus1.flush_i = flush;

    control_pipe #(.OP_W(7), .TPU_BUFS(3), .TPU_LAT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    control_pipe #(.OP_W(8), .TPU_BUFS(4), .TPU_LAT(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int op_for(int d);
        return (d == 0) ? (int'(op) & 127) : int'(op);
    endfunction

    // Reference decode straight from the opcode table.
    function automatic dec_t ref_decode(int o, int nb);
        dec_t r = '0;
        int lo = o & 127;
        int racc = 'h51 + nb;
        bit nop;
        bit legal;
        r.wb[1] = ((lo >> 4) == 5);
        r.wb[0] = ((lo >> 4) == 2);
        r.alu   = r.wb[0] ? 4'h1 : 4'(lo & 15);
        r.imm   = 1'(((lo >> 4) ^ (lo >> 5)) & 1);
        if ((lo >> 4) == 3) r.br = 2'b01;
        else if ((lo >> 1) == 63) r.br = {1'b1, 1'(lo & 1)};
        else r.br = 2'b00;
        r.regw  = (lo >= 1 && lo <= 10) || lo == 'h11 || (lo >= 'h13 && lo <= 'h19) ||
                  lo == 'h1B || lo == 'h20 || lo == racc;
        r.memw  = (lo == 'h21);
        r.start = (lo == 'h50);
        r.we    = (lo >= 'h51 && lo < racc) ? 16'(1 << (lo - 'h51)) : 16'h0;
        nop     = (lo == 0) || (lo >= 'h3C && lo <= 'h3F) || (lo >= 'h7E);
        legal   = ((o >> 7) == 0) && (r.regw || r.memw || r.start || r.we != 0 || nop);
        if (!legal) begin
            r.regw = 1'b0; r.memw = 1'b0; r.start = 1'b0; r.we = 16'h0;
        end
        r.ill = !legal;
        return r;
    endfunction

    function automatic bit exp_busy(int d);
        return (mcnt[d] > 0) || (mv[d] && mcur[d].start);
    endfunction

    function automatic bit exp_ready(int d);
        int lo = op_for(d) & 127;
        bit tpu_cls = ((op_for(d) >> 7) == 0) && lo >= 'h50 && lo <= 'h51 + bufs[d];
        return !stall && !flush && !(vin && tpu_cls && exp_busy(d));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; mcur[d] = '0; mcnt[d] = 0; mknown[d] = 1'b1;
        end
    endtask

    task automatic model_edge(int d);
        bit rdy = exp_ready(d);
        bit consume = mv[d] && mcur[d].start && !stall && !flush;
        if (consume) mcnt[d] = lat[d];
        else if (mcnt[d] > 0) mcnt[d] = mcnt[d] - 1;
        if (flush) begin
            mv[d] = 1'b0; mcur[d] = '0; mknown[d] = 1'b1;
        end else if (vin && rdy) begin
            mv[d] = 1'b1; mcur[d] = ref_decode(op_for(d), bufs[d]); mknown[d] = 1'b1;
        end else if (!stall) begin
            mv[d] = 1'b0; mcur[d] = '0; mknown[d] = 1'b0;
        end
    endtask

    task automatic check_dut(int d);
        dec_t  o;
        logic  ov, ordy, obusy;
        string p = (d == 0) ? "d0" : "d1";
        if (d == 0) begin
            ov = bus0.valid_o; ordy = bus0.ready_o; obusy = bus0.tpu_busy_o;
            o = {bus0.alu_op_o, bus0.branch_type_o, bus0.wb_sel_o, bus0.imm_sel_o,
                 bus0.reg_write_enable_o, bus0.mem_write_enable_o, bus0.tpu_start_o,
                 16'(bus0.tpu_write_enable_o), bus0.illegal_o};
            last_ready0 = ordy;
        end else begin
            ov = bus1.valid_o; ordy = bus1.ready_o; obusy = bus1.tpu_busy_o;
            o = {bus1.alu_op_o, bus1.branch_type_o, bus1.wb_sel_o, bus1.imm_sel_o,
                 bus1.reg_write_enable_o, bus1.mem_write_enable_o, bus1.tpu_start_o,
                 16'(bus1.tpu_write_enable_o), bus1.illegal_o};
        end
        chk({p, " valid_o"}, ov, mv[d]);
        chk({p, " ready_o"}, ordy, exp_ready(d));
        chk({p, " tpu_busy_o"}, obusy, exp_busy(d));
        chk({p, " illegal_o"}, o.ill, mv[d] & mcur[d].ill);
        chk({p, " reg_we"}, o.regw, mv[d] & mcur[d].regw);
        chk({p, " mem_we"}, o.memw, mv[d] & mcur[d].memw);
        chk({p, " tpu_start"}, o.start, mv[d] & mcur[d].start);
        chk({p, " tpu_we"}, o.we, mv[d] ? mcur[d].we : 16'h0);
        if (mv[d] || mknown[d]) begin
            chk({p, " alu_op"}, o.alu, mcur[d].alu);
            chk({p, " branch_type"}, o.br, mcur[d].br);
            chk({p, " wb_sel"}, o.wb, mcur[d].wb);
            chk({p, " imm_sel"}, o.imm, mcur[d].imm);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic drive(bit v, int o, bit s, bit f, int n);
        vin = v; op = 8'(o); stall = s; flush = f;
        repeat (n) cycle();
    endtask

    int zeros;
    int pool [21] = '{'h00, 'h01, 'h0A, 'h0B, 'h11, 'h12, 'h1B, 'h20, 'h21, 'h22, 'h3D,
                      'h3F, 'h50, 'h51, 'h52, 'h53, 'h54, 'h55, 'h7D, 'h7E, 'h7F};

    initial begin
        vin = 1'b0; op = 8'h00; stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_dut(0);
        check_dut(1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 'h01, 1'b0, 1'b0, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 2);
        drive(1'b1, 'h20, 1'b0, 1'b0, 1);
        drive(1'b1, 'h21, 1'b0, 1'b0, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 1);

        // Matmul followed by a held buffer load: count fetch-side hold-off.
        drive(1'b1, 'h50, 1'b0, 1'b0, 1);
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 'h51, 1'b0, 1'b0, 1);
            if (last_ready0) break;
            zeros++;
        end
        chk("d0 hazard_cycles", zeros, 17);
        drive(1'b0, 'h00, 1'b0, 1'b0, 1);

        // Non-TPU op during busy is not blocked.
        drive(1'b1, 'h50, 1'b0, 1'b0, 1);
        drive(1'b1, 'h01, 1'b0, 1'b0, 3);
        drive(1'b0, 'h00, 1'b0, 1'b0, 18);

        // Stall hold, flush, flushed matmul.
        drive(1'b1, 'h3D, 1'b0, 1'b0, 1);
        drive(1'b1, 'h3D, 1'b1, 1'b0, 3);
        drive(1'b1, 'h3D, 1'b0, 1'b1, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 1);
        drive(1'b1, 'h50, 1'b0, 1'b0, 1);
        drive(1'b0, 'h00, 1'b0, 1'b1, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 2);

        // Illegal opcodes, wide opcode, 4-buffer load and racc.
        drive(1'b1, 'h0B, 1'b0, 1'b0, 1);
        drive(1'b1, 'h7D, 1'b0, 1'b0, 1);
        drive(1'b1, 'h81, 1'b0, 1'b0, 1);
        drive(1'b1, 'h54, 1'b0, 1'b0, 1);
        drive(1'b1, 'h55, 1'b0, 1'b0, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 1);

        // Asynchronous reset while busy.
        drive(1'b1, 'h50, 1'b0, 1'b0, 1);
        drive(1'b0, 'h00, 1'b0, 1'b0, 3);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            int o;
            if ($urandom_range(0, 4) == 0) o = int'($urandom_range(0, 255));
            else begin
                o = pool[$urandom_range(0, 20)];
                if ($urandom_range(0, 7) == 0) o = o | 'h80;
            end
            drive(1'($urandom_range(0, 3) != 0), o, 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 11) == 0), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
